// File: rtl/fpga_input_handshake.sv
// fpga_input_handshake
// Turns a raw active-low confirm pushbutton and a switch bank into a
// CPU input handshake. The CPU raises FLAG_input when an input instruction
// is pending; the user sets the switches and presses confirm. The value is
// captured on a debounced press and presented on input_data with
// FPGA_input_confirm high until the CPU drops FLAG_input.
//
// Build option: define INPUT_SIGN_EXTEND_EN to sign-extend the switch value
// from bit SW_W-1 into 32 bits; without it the value is zero-extended.
// SW_W may be at most 32.

module fpga_input_handshake #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_W            = 16
) (
    input  logic            clk_50,
    input  logic            rst,
    input  logic            push_confirm,
    input  logic [SW_W-1:0] switches,
    input  logic            FLAG_input,
    output logic            FPGA_input_confirm,
    output logic [31:0]     input_data,
    output logic            waiting_led
);

    // Counter is wide enough to hold DEBOUNCE_CYCLES itself.
    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        CONFIRMED  = 2'd2
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             stable_q;
    logic             stable_d;
    logic             prev_q;
    logic             press;
    logic [31:0]      ext_data;

    state_t           state_q;
    logic             confirm_q;
    logic             led_q;
    logic [31:0]      data_q;

    // Bring the asynchronous button into the clock domain; idle level is 1.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= push_confirm;
            sync2_q <= sync1_q;
        end
    end

    assign cnt_inc = cnt_q + CNT_ONE;

    // A new level is accepted only after it differs from the stable level
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_inc == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    // Debounce state runs every cycle regardless of the handshake state.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
            prev_q   <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
        end
    end

    // One-cycle pulse on the debounced falling edge (button pressed).
    assign press = prev_q & ~stable_q;

`ifdef INPUT_SIGN_EXTEND_EN
    assign ext_data = 32'($signed(switches));
`else
    assign ext_data = 32'(switches);
`endif

    // Handshake sequencer; outputs are registered alongside the state so
    // they track it exactly. Dropping FLAG_input always wins over a press.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            confirm_q <= 1'b0;
            led_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (FLAG_input) begin
                        state_q <= WAIT_PRESS;
                        led_q   <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (!FLAG_input) begin
                        state_q <= IDLE;
                        led_q   <= 1'b0;
                    end else if (press) begin
                        state_q   <= CONFIRMED;
                        led_q     <= 1'b0;
                        confirm_q <= 1'b1;
                        data_q    <= ext_data;
                    end
                end
                CONFIRMED: begin
                    if (!FLAG_input) begin
                        state_q   <= IDLE;
                        confirm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    confirm_q <= 1'b0;
                    led_q     <= 1'b0;
                end
            endcase
        end
    end

    assign FPGA_input_confirm = confirm_q;
    assign waiting_led        = led_q;
    assign input_data         = data_q;

endmodule

// File: tb/tb_fpga_input_handshake.sv
// tb_fpga_input_handshake
// Drives fpga_input_handshake (DEBOUNCE_CYCLES=4, SW_W=16) with directed
// scenarios and a randomized run, comparing against a behavioural model.
// Honours INPUT_SIGN_EXTEND_EN the same way as the design.

module tb_fpga_input_handshake;

    logic        clk_50 = 1'b0;
    logic        rst;
    logic        push_confirm;
    logic [15:0] switches;
    logic        FLAG_input;
    logic        FPGA_input_confirm;
    logic [31:0] input_data;
    logic        waiting_led;

    int checkCount = 0;
    int passCount  = 0;

`ifdef INPUT_SIGN_EXTEND_EN
    localparam logic [31:0] EXP_8001 = 32'hFFFF8001;
`else
    localparam logic [31:0] EXP_8001 = 32'h00008001;
`endif

    fpga_input_handshake #(
        .DEBOUNCE_CYCLES(4),
        .SW_W(16)
    ) dut (
        .clk_50(clk_50),
        .rst(rst),
        .push_confirm(push_confirm),
        .switches(switches),
        .FLAG_input(FLAG_input),
        .FPGA_input_confirm(FPGA_input_confirm),
        .input_data(input_data),
        .waiting_led(waiting_led)
    );

    // 50 MHz clock.
    always #10 clk_50 = ~clk_50;

    function automatic logic [31:0] ext(input logic [15:0] s);
`ifdef INPUT_SIGN_EXTEND_EN
        return {{16{s[15]}}, s};
`else
        return {16'h0000, s};
`endif
    endfunction

    // Behavioural model: button delayed two cycles, a 4-sample window of the
    // delayed level decides acceptance, and the handshake is tracked as
    // "waiting" / "confirmed" flags driven straight from the rules.
    logic        mSync1 = 1'b1;
    logic        mSync2 = 1'b1;
    logic [3:0]  mHist  = 4'b1111;
    logic        mStable = 1'b1;
    logic        mPrev   = 1'b1;
    logic        mWait   = 1'b0;
    logic        mConf   = 1'b0;
    logic [31:0] mData   = 32'h0;
    wire  [3:0]  newHist = {mHist[2:0], mSync2};
    wire         mPress  = mPrev & ~mStable;

    // Advance the model on every clock edge; reset clears it at once.
    always @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            mSync1  <= 1'b1;
            mSync2  <= 1'b1;
            mHist   <= 4'b1111;
            mStable <= 1'b1;
            mPrev   <= 1'b1;
            mWait   <= 1'b0;
            mConf   <= 1'b0;
            mData   <= 32'h0;
        end else begin
            mSync1 <= push_confirm;
            mSync2 <= mSync1;
            mHist  <= newHist;
            mPrev  <= mStable;
            if (mStable ? (newHist == 4'b0000) : (newHist == 4'b1111))
                mStable <= ~mStable;
            if (!FLAG_input) begin
                mWait <= 1'b0;
                mConf <= 1'b0;
            end else if (!mWait && !mConf) begin
                mWait <= 1'b1;
            end else if (mWait && mPress) begin
                mWait <= 1'b0;
                mConf <= 1'b1;
                mData <= ext(switches);
            end
        end
    end

    wire [33:0] expVec = {mConf, mWait, mData};
    wire [33:0] obsVec = {FPGA_input_confirm, waiting_led, input_data};

    task automatic applyStimulus(input logic flag, input logic btn, input logic [15:0] sw);
        FLAG_input   = flag;
        push_confirm = btn;
        switches     = sw;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h0000);
        repeat (2) @(negedge clk_50);
        checkCount++;
        if (obsVec !== 34'h0) $display("[TB] FAIL reset_outputs: got %h expected %h", obsVec, 34'h0);
        else passCount++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== 34'h0) $display("[TB] FAIL reset_idle: got %h expected %h", obsVec, 34'h0);
            else passCount++;
        end
    endtask

    task automatic test_clean_press();
        applyStimulus(1'b1, 1'b1, 16'h00A5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL clean_pre: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        checkCount++;
        if (waiting_led !== 1'b1) $display("[TB] FAIL clean_led: got %b expected 1", waiting_led);
        else passCount++;
        applyStimulus(1'b1, 1'b0, 16'h00A5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL clean_hold: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        checkCount++;
        if (obsVec !== {1'b1, 1'b0, 32'h000000A5})
            $display("[TB] FAIL clean_capture: got %h expected %h", obsVec, {1'b1, 1'b0, 32'h000000A5});
        else passCount++;
        applyStimulus(1'b0, 1'b0, 16'h00A5);
        @(negedge clk_50);
        checkCount++;
        if (FPGA_input_confirm !== 1'b0) $display("[TB] FAIL clean_drop: got %b expected 0", FPGA_input_confirm);
        else passCount++;
        applyStimulus(1'b0, 1'b1, 16'h00A5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL clean_release: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
    endtask

    task automatic test_bounce();
        applyStimulus(1'b1, 1'b1, 16'h5A5A);
        repeat (2) @(negedge clk_50);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, k[0], 16'h5A5A);
            for (int i = 0; i < 2; i++) begin
                @(negedge clk_50);
                checkCount++;
                if (obsVec !== expVec) $display("[TB] FAIL bounce_cycle: got %h expected %h", obsVec, expVec);
                else passCount++;
            end
        end
        applyStimulus(1'b1, 1'b1, 16'h5A5A);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL bounce_settle: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        checkCount++;
        if ({FPGA_input_confirm, waiting_led} !== 2'b01)
            $display("[TB] FAIL bounce_state: got %b expected 01", {FPGA_input_confirm, waiting_led});
        else passCount++;
        applyStimulus(1'b0, 1'b1, 16'h5A5A);
        @(negedge clk_50);
    endtask

    task automatic test_abort();
        logic found     = 1'b0;
        logic sawConfirm = 1'b0;
        applyStimulus(1'b1, 1'b1, 16'h1234);
        repeat (3) @(negedge clk_50);
        applyStimulus(1'b1, 1'b0, 16'h1234);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL abort_wait: got %h expected %h", obsVec, expVec);
            else passCount++;
            if (mPress) begin
                FLAG_input = 1'b0;
                found = 1'b1;
            end
        end
        checkCount++;
        if (!found) $display("[TB] FAIL abort_press_seen: got 0 expected 1");
        else passCount++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_50);
            if (FPGA_input_confirm === 1'b1) sawConfirm = 1'b1;
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL abort_after: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        checkCount++;
        if ({sawConfirm, obsVec} !== {1'b0, 2'b00, 32'h000000A5})
            $display("[TB] FAIL abort_result: got %h expected %h", {sawConfirm, obsVec}, {1'b0, 2'b00, 32'h000000A5});
        else passCount++;
        applyStimulus(1'b0, 1'b1, 16'h1234);
        repeat (10) @(negedge clk_50);
    endtask

    task automatic test_sign_extend();
        applyStimulus(1'b1, 1'b1, 16'h8001);
        repeat (2) @(negedge clk_50);
        applyStimulus(1'b1, 1'b0, 16'h8001);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL sext_cycle: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        checkCount++;
        if (obsVec !== {1'b1, 1'b0, EXP_8001})
            $display("[TB] FAIL sext_value: got %h expected %h", obsVec, {1'b1, 1'b0, EXP_8001});
        else passCount++;
        applyStimulus(1'b0, 1'b1, 16'h8001);
        repeat (10) @(negedge clk_50);
    endtask

    task automatic test_idle_press();
        logic [15:0] sw = 16'($urandom);
        applyStimulus(1'b0, 1'b0, sw);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL idle_held: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        applyStimulus(1'b1, 1'b0, sw);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL idle_flag_held: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        checkCount++;
        if (obsVec !== {1'b0, 1'b1, EXP_8001})
            $display("[TB] FAIL idle_no_capture: got %h expected %h", obsVec, {1'b0, 1'b1, EXP_8001});
        else passCount++;
        applyStimulus(1'b1, 1'b1, sw);
        repeat (10) @(negedge clk_50);
        applyStimulus(1'b1, 1'b0, sw);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL idle_repress: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        checkCount++;
        if (obsVec !== {1'b1, 1'b0, ext(sw)})
            $display("[TB] FAIL idle_new_capture: got %h expected %h", obsVec, {1'b1, 1'b0, ext(sw)});
        else passCount++;
        applyStimulus(1'b0, 1'b1, sw);
        repeat (10) @(negedge clk_50);
    endtask

    task automatic test_reset_confirmed();
        applyStimulus(1'b1, 1'b1, 16'h3C3C);
        repeat (2) @(negedge clk_50);
        applyStimulus(1'b1, 1'b0, 16'h3C3C);
        repeat (10) @(negedge clk_50);
        applyStimulus(1'b1, 1'b1, 16'h3C3C);
        repeat (8) @(negedge clk_50);
        checkCount++;
        if (obsVec !== {1'b1, 1'b0, 32'h00003C3C})
            $display("[TB] FAIL rstconf_before: got %h expected %h", obsVec, {1'b1, 1'b0, 32'h00003C3C});
        else passCount++;
        #3 rst = 1'b1;
        #1;
        checkCount++;
        if (obsVec !== 34'h0) $display("[TB] FAIL rstconf_async: got %h expected %h", obsVec, 34'h0);
        else passCount++;
        @(negedge clk_50);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL rstconf_after: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        checkCount++;
        if (obsVec !== {1'b0, 1'b1, 32'h0})
            $display("[TB] FAIL rstconf_waiting: got %h expected %h", obsVec, {1'b0, 1'b1, 32'h0});
        else passCount++;
        applyStimulus(1'b1, 1'b0, 16'h3C3C);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL rstconf_press: got %h expected %h", obsVec, expVec);
            else passCount++;
        end
        checkCount++;
        if (obsVec !== {1'b1, 1'b0, 32'h00003C3C})
            $display("[TB] FAIL rstconf_recapture: got %h expected %h", obsVec, {1'b1, 1'b0, 32'h00003C3C});
        else passCount++;
        applyStimulus(1'b0, 1'b1, 16'h3C3C);
        repeat (10) @(negedge clk_50);
    endtask

    task automatic test_random();
        int   flagLeft = 0;
        int   btnLeft  = 0;
        logic f = 1'b0;
        logic b = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_50);
            checkCount++;
            if (obsVec !== expVec) $display("[TB] FAIL random_cycle %0d: got %h expected %h", i, obsVec, expVec);
            else passCount++;
            if (flagLeft == 0) begin
                f = 1'($urandom_range(0, 1));
                flagLeft = int'($urandom_range(5, 40));
            end else begin
                flagLeft--;
            end
            if (btnLeft == 0) begin
                b = 1'($urandom_range(0, 1));
                btnLeft = int'($urandom_range(1, 10));
            end else begin
                btnLeft--;
            end
            applyStimulus(f, b, 16'($urandom));
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_abort();
        test_sign_extend();
        test_idle_press();
        test_reset_confirmed();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fpga_input_handshake.md
FPGA_INPUT_HANDSHAKE -- requirements
Module: fpga_input_handshake

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 50000, cycles a confirm-button level change must persist before acceptance (≈1 ms at 50 MHz).
REQ-002 Parameter: SW_W, 16, width of the switch bank.
REQ-003 Port: clk_50  input  1  single system clock; all state on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: push_confirm  input  1  raw confirm pushbutton, active-low, unsynchronised.
REQ-006 Port: switches  input  SW_W  raw user switch bank holding the value to enter.
REQ-007 Port: FLAG_input  input  1  level from the CPU: an input instruction is pending.
REQ-008 Port: FPGA_input_confirm  output  1  registered; user value captured and valid on input_data.
REQ-009 Port: input_data  output  32  registered captured value, extended to 32 bits.
REQ-010 Port: waiting_led  output  1  registered; high while waiting for a user press.

Function
REQ-011 push_confirm SHALL pass a 2-flop synchroniser (both flops reset to 1) before any other use.
REQ-012 Debounce: counter SHALL increment each cycle the synchronised level differs from the stable level, clear whenever they match, and on reaching DEBOUNCE_CYCLES load the stable level and clear.
REQ-013 A press event SHALL be a one-cycle pulse when the previous stable level is 1 and the current stable level is 0; the stable level and previous level both reset to 1.
REQ-014 FSM states SHALL be IDLE, WAIT_PRESS, CONFIRMED; reset state IDLE.
REQ-015 IDLE -> WAIT_PRESS when FLAG_input=1; press events in IDLE SHALL be ignored.
REQ-016 WAIT_PRESS -> CONFIRMED on a press event while FLAG_input=1; the same edge SHALL latch switches into input_data.
REQ-017 WAIT_PRESS -> IDLE when FLAG_input=0; if a press event coincides, the abort SHALL win and input_data SHALL remain unchanged.
REQ-018 CONFIRMED -> IDLE on the first cycle FLAG_input=0; further press events in CONFIRMED SHALL be ignored.
REQ-019 FPGA_input_confirm SHALL be 1 exactly while the state is CONFIRMED, i.e. from the cycle after the capturing edge.
REQ-020 waiting_led SHALL be 1 exactly while the state is WAIT_PRESS.
REQ-021 input_data SHALL hold its last captured value until the next capture.
REQ-022 The debounce path SHALL run continuously, independent of FSM state.

Reset
REQ-023 On rst=1, asynchronously: state=IDLE, FPGA_input_confirm=0, waiting_led=0, input_data=0, debounce counter=0, synchroniser, stable and previous levels=1.
REQ-024 Reset asserted mid-operation, including in CONFIRMED, SHALL abandon the transaction; after release a new FLAG_input assertion SHALL require a fresh press.

Configuration
REQ-025 Macro INPUT_SIGN_EXTEND_EN defined: input_data SHALL be switches sign-extended from bit SW_W-1.
REQ-026 Macro INPUT_SIGN_EXTEND_EN undefined: input_data SHALL be switches zero-extended.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 FLAG_input=1, switches=16'h00A5, clean press held 20 cycles -> waiting_led high until capture; input_data=32'h000000A5; FPGA_input_confirm rises the cycle after capture and stays high until FLAG_input=0, then falls the next cycle.
REQ-028 FLAG_input=1, button bounces low/high every 2 cycles for 12 cycles, then released -> no press event, FPGA_input_confirm stays 0, state remains WAIT_PRESS.
REQ-029 In WAIT_PRESS, FLAG_input falls on the same cycle as the press event -> state IDLE, input_data unchanged, FPGA_input_confirm never asserts.
REQ-030 switches=16'h8001 captured -> input_data=32'hFFFF8001 with INPUT_SIGN_EXTEND_EN defined, 32'h00008001 without it.
REQ-031 Press held in IDLE (FLAG_input=0), then FLAG_input raised while still held -> no capture until release and a new press.
REQ-032 rst pulsed during CONFIRMED -> all outputs 0 immediately, without waiting for a clock edge; FLAG_input kept at 1 -> WAIT_PRESS again, fresh press required.
